// File: rtl/sine_phase_gen_pkg.sv
// Shared definitions for the sine-wave address path: FSM encodings and the
// default geometry the sine ROM instance is built with.
package sine_phase_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam int DEF_DEPTH   = 64;
  localparam int DEF_PHASE_W = 16;
  localparam int DEF_DIV_W   = 16;

endpackage

// File: rtl/sine_phase_gen_tick_gen.sv
// Sample-rate divider: fires tick once every tick_div+1 enabled cycles,
// counting from zero after a clear.
module tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] tick_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  assign tick = en && (div_cnt == tick_div);

  // tick_div lowered below div_cnt simply lets the counter roll over
  always_ff @(posedge clk) begin
    if (!rst_n)      div_cnt <= '0;
    else if (clr)    div_cnt <= '0;
    else if (tick)   div_cnt <= '0;
    else if (en)     div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/sine_phase_gen.sv
// Phase-accumulator address generator feeding the sine ROM; playback always
// ends on a full waveform period.
module sine_phase_gen
  import sine_phase_gen_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DIV_W   = DEF_DIV_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [DIV_W-1:0]   tick_div,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  output logic               sample_valid,
  output logic               wrap,
  output logic               busy
);

  localparam int STAGES = 1;

  state_t             state, state_nxt;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   sum;
  logic [STAGES:0]    vld_pipe;

  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != ST_IDLE),
    .clr      (state == ST_IDLE),
    .tick_div (tick_div),
    .tick     (tick)
  );

  assign sum = {1'b0, phase} + {1'b0, ftw};

  // a zero ftw can never carry, so it must not trap STOPPING forever
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_RUN;
      ST_RUN:      if (stop)  state_nxt = ST_STOPPING;
      ST_STOPPING: if (tick && (sum[PHASE_W] || ftw == '0)) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= '0;
      rom_addr <= '0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != ST_IDLE);
      vld_pipe <= {vld_pipe[STAGES-1:0], tick};
      wrap     <= tick & sum[PHASE_W];
      if (state == ST_IDLE) phase <= '0;
      else if (tick)        phase <= sum[PHASE_W-1:0];
      if (tick) rom_addr <= phase[PHASE_W-1 -: AW];
    end
  end

  // stage 0 is the ROM read strobe, stage 1 lines up with the ROM's data
  assign rom_en       = vld_pipe[0];
  assign sample_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sine_phase_gen.sv
// Randomized scoreboard bench for sine_phase_gen against a closed-form
// sample-schedule model.
module tb_sine_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [15:0] ftw, tick_div;
  logic        rom_en, sample_valid, wrap, busy;
  logic [5:0]  rom_addr;

  sine_phase_gen #(.DEPTH(64), .PHASE_W(16), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .ftw          (ftw),
    .tick_div     (tick_div),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {
    int t;
    int addr;
    bit wrap;
  } exp_t;

  exp_t eq[$];
  int   vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every rom_en / sample_valid must match the next scheduled entry
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (rom_en === 1'b1) begin
      if (eq.size() == 0) chk("unexpected rom_en", 1, 0);
      else begin
        e = eq.pop_front();
        chk("rom_en cycle", cyc, e.t);
        chk("rom_addr", {26'd0, rom_addr}, e.addr);
        chk("wrap", {31'd0, wrap}, {31'd0, e.wrap});
      end
    end else if (wrap !== 1'b0) chk("wrap without rom_en", {31'd0, wrap}, 0);
    if (sample_valid === 1'b1) begin
      if (vq.size() == 0) chk("unexpected sample_valid", 1, 0);
      else begin
        v = vq.pop_front();
        chk("sample_valid cycle", cyc, v);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One playback: start sampled at edge E, optional stop pulse at E+stop_dly,
  // optional reset at E+rst_dly. Expected samples come from phase arithmetic.
  task automatic run(input logic [15:0] f, input logic [15:0] td, input int stop_dly,
                     input bit start_stop, input int rst_dly);
    int E, S, R, last, T, p;
    bit w;
    exp_t e;
    ftw = f; tick_div = td; start = 1'b1; stop = start_stop;
    E = cyc + 1;
    S = (stop_dly > 0) ? E + stop_dly : 0;
    R = (rst_dly > 0) ? E + rst_dly : 0;
    last = 0;
    for (int k = 0; k < 8192; k++) begin
      T = E + 1 + int'(td) + k * (int'(td) + 1);
      p = int'((longint'(k) * longint'(f)) % 65536);
      w = (p + int'(f)) >= 65536;
      if (R > 0 && T >= R) break;
      e.t = T; e.addr = p >> 10; e.wrap = w;
      eq.push_back(e);
      if (R == 0 || T + 1 < R) vq.push_back(T + 1);
      if (S > 0 && T > S && (w || f == 16'd0)) begin
        last = T;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("busy after start", {31'd0, busy}, 1);
    if (S > 0) begin
      wait_cyc(S - 1);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
    if (R > 0) begin
      wait_cyc(R - 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rom_en after reset", {31'd0, rom_en}, 0);
      chk("sample_valid after reset", {31'd0, sample_valid}, 0);
      chk("busy after reset", {31'd0, busy}, 0);
      rst_n = 1'b1;
    end else begin
      wait_cyc(last);
      chk("busy after last sample", {31'd0, busy}, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("samples outstanding", eq.size(), 0);
    chk("valids outstanding", vq.size(), 0);
    eq.delete();
    vq.delete();
  endtask

  initial begin
    logic [15:0] f, td;
    int sd, rd;
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; ftw = 16'h0400; tick_div = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset outputs", {27'd0, rom_en, sample_valid, wrap, busy, |rom_addr}, 0);
    end
    rst_n = 1'b1;
    run(16'h0400, 16'd0, 70, 1'b0, 0);   // full periods at full rate: 0..63,0..63
    repeat (2) @(posedge clk);
    #1;
    run(16'h0800, 16'd3, 20, 1'b0, 0);   // divided rate, even addresses
    run(16'h0400, 16'd1, 22, 1'b0, 0);   // stop requested around addr 10
    run(16'h0000, 16'd2, 5, 1'b1, 0);    // start+stop together, then stop at ftw=0
    run(16'h0400, 16'd0, 0, 1'b0, 15);   // reset mid-run
    run(16'h0400, 16'd0, 3, 1'b0, 0);    // restart from addr 0
    for (int i = 0; i < 14; i++) begin
      f  = 16'($urandom_range(16'hFFFF, 16'h0100));
      if ($urandom_range(0, 9) == 0) f = 16'd0;
      td = 16'($urandom_range(0, 3));
      sd = $urandom_range(1, 200);
      rd = 0;
      if ($urandom_range(0, 4) == 0) begin
        rd = $urandom_range(1, 60);
        sd = 0;
      end
      run(f, td, sd, 1'($urandom_range(0, 1)), rd);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
